stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl_if.sv | 23 ++
 rtl/stall_ctrl.sv | 93 +++++++++
 tb/tb_stall_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stall_ctrl_if.sv
// Decode-stage hazard interface: operand/destination info in, stall and forward selects out.
interface stall_ctrl_if;
  logic [4:0]  rs_D;
  logic [4:0]  rt_D;
  logic [1:0]  Tuse_rs;
  logic [1:0]  Tuse_rt;
  logic [4:0]  dst_D;
  logic [1:0]  Tnew_D;
  logic        stall;
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
  logic [15:0] stall_cnt;

  modport master (
    output rs_D, rt_D, Tuse_rs, Tuse_rt, dst_D, Tnew_D,
    input  stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );

  modport slave (
    input  rs_D, rt_D, Tuse_rs, Tuse_rt, dst_D, Tnew_D,
    output stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );
endinterface

// File: rtl/stall_ctrl.sv
// Tuse/Tnew hazard unit: E/M/W scoreboard drives decode stall and operand forward selects.
module stall_ctrl (
  input  logic         clk,
  input  logic         reset,
  stall_ctrl_if.slave  bus
);

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } sb_ent_t;

  sb_ent_t     e_q, m_q, w_q;
  sb_ent_t     e_d, m_d, w_d;
  logic [15:0] cnt_q, cnt_d;
  logic        hz_rs, hz_rt, stall_w;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // r != 0 also keeps bubble entries (dst == 0) from ever matching.
  function automatic logic hazard(input logic [4:0] r, input logic [1:0] tuse,
                                  input sb_ent_t e, input sb_ent_t m);
    logic hit_e, hit_m;
    hit_e = (e.dst == r) && (e.tnew > tuse);
    hit_m = (m.dst == r) && (m.tnew > tuse);
    return (r != 5'd0) && (tuse != 2'd3) && (hit_e || hit_m);
  endfunction

  // Youngest match decides; a not-yet-ready younger producer masks older ready ones.
  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input sb_ent_t e,
                                         input sb_ent_t m, input sb_ent_t w);
    logic [1:0] sel;
    sel = 2'd0;
    if (r == 5'd0) begin
      sel = 2'd0;
    end else if (e.dst == r) begin
      sel = (e.tnew == 2'd0) ? 2'd1 : 2'd0;
    end else if (m.dst == r) begin
      sel = (m.tnew == 2'd0) ? 2'd2 : 2'd0;
    end else if (w.dst == r) begin
      sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    hz_rs   = hazard(bus.rs_D, bus.Tuse_rs, e_q, m_q);
    hz_rt   = hazard(bus.rt_D, bus.Tuse_rt, e_q, m_q);
    stall_w = hz_rs | hz_rt;
  end

  always_comb begin
    bus.stall      = stall_w;
    bus.fwd_rs_sel = fwd_sel(bus.rs_D, e_q, m_q, w_q);
    bus.fwd_rt_sel = fwd_sel(bus.rt_D, e_q, m_q, w_q);
    bus.stall_cnt  = cnt_q;
  end

  always_comb begin
    e_d   = '0;
    m_d   = '0;
    w_d   = '0;
    cnt_d = cnt_q;
    if (!stall_w) begin
      e_d.dst  = bus.dst_D;
      e_d.tnew = bus.Tnew_D;
    end
    m_d.dst  = e_q.dst;
    m_d.tnew = dec_sat(e_q.tnew);
    w_d.dst  = m_q.dst;
    w_d.tnew = dec_sat(m_q.tnew);
    if (stall_w && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Randomised and directed bench for stall_ctrl against an in-flight-instruction model.
module tb_stall_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stall_ctrl_if bus ();

  stall_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: each in-flight instruction remembers the cycle it entered E; its stage is its age.
  typedef struct {
    int dst;
    int tnew;
    int t_in;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   cnt_m = 0;

  function automatic void eval(input int r, input int tuse, output bit hz, output int sel);
    bit found;
    int age, rem;
    hz = 0;
    sel = 0;
    found = 0;
    foreach (q[i]) begin
      age = cyc - q[i].t_in;
      rem = (q[i].tnew > age) ? q[i].tnew - age : 0;
      if (r != 0 && q[i].dst == r && age <= 2) begin
        if (age <= 1 && tuse != 3 && rem > tuse) hz = 1;
        if (!found) begin
          found = 1;
          sel = (rem == 0) ? age + 1 : 0;
        end
      end
    end
  endfunction

  task automatic tick();
    bit   h1, h2;
    int   s1, s2;
    ent_t n;
    eval(int'(bus.rs_D), int'(bus.Tuse_rs), h1, s1);
    eval(int'(bus.rt_D), int'(bus.Tuse_rt), h2, s2);
    if (!reset) begin
      q.delete();
      cnt_m = 0;
    end else begin
      n.dst  = (h1 | h2) ? 0 : int'(bus.dst_D);
      n.tnew = (h1 | h2) ? 0 : int'(bus.Tnew_D);
      n.t_in = cyc + 1;
      q.push_front(n);
      if (q.size() > 3) void'(q.pop_back());
      if ((h1 | h2) && cnt_m < 65535) cnt_m++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(input int rs, input int trs, input int rt, input int trt,
                       input int dst, input int tn);
    bus.rs_D    = 5'(rs);
    bus.Tuse_rs = 2'(trs);
    bus.rt_D    = 5'(rt);
    bus.Tuse_rt = 2'(trt);
    bus.dst_D   = 5'(dst);
    bus.Tnew_D  = 2'(tn);
    #4;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 3, 0, 3, 0, 0);
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(7, 0, 9, 0, 0, 0);
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%0b want=0", bus.stall);
    end
    checks++;
    if (bus.fwd_rs_sel !== 2'd0 || bus.fwd_rt_sel !== 2'd0) begin
      failures++;
      $display("FAIL reset_fwd got=%0d/%0d want=0/0", bus.fwd_rs_sel, bus.fwd_rt_sel);
    end
    checks++;
    if (bus.stall_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d want=0", bus.stall_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(0, 3, 0, 3, 8, 2);
    tick();
    for (int c = 1; c <= 3; c++) begin
      drive(8, 0, 0, 3, 0, 0);
      checks++;
      if (bus.stall !== (c < 3)) begin
        failures++; $display("FAIL load_use_stall c=%0d got=%0b want=%0b", c, bus.stall, c < 3);
      end
      if (c < 3) tick();
    end
    checks++;
    if (bus.fwd_rs_sel !== 2'd3) begin
      failures++; $display("FAIL load_use_fwd got=%0d want=3", bus.fwd_rs_sel);
    end
    checks++;
    if (bus.stall_cnt !== 16'd2) begin
      failures++; $display("FAIL load_use_cnt got=%0d want=2", bus.stall_cnt);
    end
    tick();
  endtask

  task automatic test_alu_branch();
    do_reset();
    drive(0, 3, 0, 3, 9, 1);
    tick();
    drive(0, 3, 9, 0, 0, 0);
    checks++;
    if (bus.stall !== 1'b1) begin
      failures++; $display("FAIL alu_branch_stall got=%0b want=1", bus.stall);
    end
    tick();
    drive(0, 3, 9, 0, 0, 0);
    checks++;
    if (bus.stall !== 1'b0 || bus.fwd_rt_sel !== 2'd2) begin
      failures++;
      $display("FAIL alu_branch_fwd got=%0b/%0d want=0/2", bus.stall, bus.fwd_rt_sel);
    end
    tick();
  endtask

  task automatic test_alu_alu();
    do_reset();
    drive(0, 3, 0, 3, 10, 1);
    tick();
    drive(10, 1, 0, 3, 0, 0);
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL alu_alu_stall got=%0b want=0", bus.stall);
    end
    tick();
    drive(10, 1, 0, 3, 0, 0);
    checks++;
    if (bus.fwd_rs_sel !== 2'd2) begin
      failures++; $display("FAIL alu_alu_fwd got=%0d want=2", bus.fwd_rs_sel);
    end
    tick();
  endtask

  task automatic test_reg_zero();
    do_reset();
    drive(0, 3, 0, 3, 0, 2);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.stall !== 1'b0 || bus.fwd_rs_sel !== 2'd0) begin
      failures++;
      $display("FAIL reg_zero got=%0b/%0d want=0/0", bus.stall, bus.fwd_rs_sel);
    end
    tick();
  endtask

  task automatic test_youngest();
    do_reset();
    drive(0, 3, 0, 3, 5, 1);
    tick();
    drive(0, 3, 0, 3, 5, 1);
    tick();
    // E = {5,1} is younger and not ready; M = {5,0} must not be chosen.
    drive(5, 1, 0, 3, 0, 0);
    checks++;
    if (bus.stall !== 1'b0 || bus.fwd_rs_sel !== 2'd0) begin
      failures++;
      $display("FAIL youngest_first got=%0b/%0d want=0/0", bus.stall, bus.fwd_rs_sel);
    end
    tick();
    drive(5, 1, 0, 3, 0, 0);
    checks++;
    if (bus.fwd_rs_sel !== 2'd2) begin
      failures++; $display("FAIL youngest_next got=%0d want=2", bus.fwd_rs_sel);
    end
    tick();
  endtask

  task automatic test_random();
    bit h1, h2;
    int s1, s2;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      eval(int'(bus.rs_D), int'(bus.Tuse_rs), h1, s1);
      eval(int'(bus.rt_D), int'(bus.Tuse_rt), h2, s2);
      checks++;
      if (bus.stall !== (h1 | h2)) begin
        failures++; $display("FAIL rand_stall n=%0d got=%0b want=%0b", n, bus.stall, h1 | h2);
      end
      checks++;
      if (int'(bus.fwd_rs_sel) != s1 || int'(bus.fwd_rt_sel) != s2) begin
        failures++;
        $display("FAIL rand_fwd n=%0d got=%0d/%0d want=%0d/%0d", n, bus.fwd_rs_sel,
                 bus.fwd_rt_sel, s1, s2);
      end
      tick();
      checks++;
      if (int'(bus.stall_cnt) != cnt_m) begin
        failures++; $display("FAIL rand_cnt n=%0d got=%0d want=%0d", n, bus.stall_cnt, cnt_m);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_saturation();
    int n;
    do_reset();
    // Self-dependent load repeated: two stalled cycles in every three.
    drive(8, 0, 0, 3, 8, 2);
    n = 0;
    while (cnt_m < 65535 && n < 99000) begin
      tick();
      n++;
    end
    checks++;
    if (cnt_m < 65535) begin
      failures++; $display("FAIL sat_budget got=%0d want=65535", cnt_m);
    end
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (bus.stall_cnt !== 16'hFFFF) begin
      failures++; $display("FAIL sat_cnt got=%0h want=ffff", bus.stall_cnt);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #4;
    checks++;
    if (bus.stall_cnt !== 16'd0 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL sat_reset got=%0h/%0b want=0/0", bus.stall_cnt, bus.stall);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rs_D = '0; bus.rt_D = '0; bus.Tuse_rs = 2'd3; bus.Tuse_rt = 2'd3;
    bus.dst_D = '0; bus.Tnew_D = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_alu_branch();
    test_alu_alu();
    test_reg_zero();
    test_youngest();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
